writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Sits directly upstream of the 4x8-bit register file and drives its single write port (write_enable / write_addr / write_data).
- Merges two result sources: ALU results, which are unbuffered, and load results from the memory path, which pass through a small FIFO.
- Arbitrates round-robin between the two sources and issues at most one registered write per cycle.
- Exports a per-register pending mask so the issue stage can stall on destinations that still have queued load results.

Parameters:
- DEPTH, 2: load-result FIFO entries; power of two, >= 2.
- DW, 8: data width; must match the register file.
- AW, 2: register address width; the register file holds 2**AW = 4 entries.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result is present.
- alu_addr  in  AW  ALU destination register.
- alu_data  in  DW  ALU result value.
- alu_ready  out  1  ALU result is accepted this cycle when alu_valid is also high.
- mem_valid  in  1  load result is present.
- mem_addr  in  AW  load destination register.
- mem_data  in  DW  load result value.
- mem_ready  out  1  FIFO can accept a load result this cycle.
- write_enable  out  1  register-file write strobe (registered).
- write_addr  out  AW  register-file write address (registered).
- write_data  out  DW  register-file write data (registered).
- pending  out  2**AW  bit r is set while any valid FIFO entry targets register r.
- fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (synchronous, active-high):
  - Clears write_enable, write_addr, write_data, the FIFO pointers and fifo_count.
  - Sets last_grant to MEM.
  - After reset: pending = 0, mem_ready = 1, alu_ready = 1.
  - Reset mid-operation discards all queued load results; nothing is written.
- Handshakes:
  - A transfer occurs when valid && ready in the same cycle.
  - ready never depends combinationally on the same source's valid.
  - A source holds addr and data stable while valid is high and ready is low.
- Load FIFO:
  - mem_ready = (fifo_count != DEPTH).
  - When full, no push occurs, even if a pop happens in the same cycle (no pass-through).
  - Push and pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- Arbiter (evaluated each cycle):
  - Requesters are alu_valid and fifo_nonempty (the FIFO head). Freshly arriving mem data is never a requester that cycle.
  - Single requester: that requester is granted.
  - Both requesting: grant the one that is not last_grant.
  - last_grant updates only when a grant occurs.
  - alu_ready = fifo_empty || (last_grant == MEM).
  - A FIFO pop occurs when the FIFO is nonempty and the ALU is not granted.
- Write port:
  - Write port registers load on every edge.
  - On a grant: write_enable <= 1, and write_addr / write_data <= the granted source's addr / data.
  - No grant: write_enable <= 0, and write_addr / write_data hold their previous values.
- Latency:
  - ALU result accepted in cycle N: write_enable is high in cycle N+1.
  - Load result pushed in cycle N: earliest write is in cycle N+2.
  - Maximum one write per cycle; sustained throughput is 1 write/cycle.
- Pending mask:
  - Combinational OR over valid FIFO entries of onehot(entry addr).
  - A bit clears in the cycle after its last matching entry pops, i.e. the same cycle that write appears on the port.
  - Entries in the output register are not counted.
- Ordering:
  - Order is preserved within each source.
  - Cross-source ordering to the same register is the issue stage's responsibility, enforced via pending.
- Starvation:
  - With both sources continuously requesting, grants alternate, so each source waits at most 1 cycle.

Test Plan:
- Reset then idle:
  - write_enable = 0, pending = 4'b0000, fifo_count = 0, mem_ready = 1, alu_ready = 1.
  - Assert reset for 2 cycles mid-stream with 2 FIFO entries queued: both are dropped and no write occurs.
- ALU only:
  - alu_valid for 1 cycle with addr = 2, data = 8'hA5.
  - Next cycle: write_enable = 1, write_addr = 2, write_data = 8'hA5.
  - Following cycle: write_enable = 0.
- Load fill to full:
  - Hold alu_valid high continuously, and push mem addr = 1 / 8'h11, then addr = 3 / 8'h33 on consecutive cycles.
  - fifo_count reaches 2, mem_ready = 0, pending = 4'b1010.
  - Writes alternate ALU, MEM(1, 8'h11), ALU, MEM(3, 8'h33).
  - pending returns to 0 after the second load write.
- Round-robin tie:
  - FIFO holds one entry (0, 8'h44), alu_valid is high, last_grant = MEM after reset.
  - ALU is granted first; the FIFO entry is written in the following cycle.
- Full with simultaneous pop:
  - FIFO full and mem_valid held high: a pop occurs but mem_ready stays 0 that cycle.
  - The push happens the following cycle, so fifo_count goes 2 -> 1 -> 2.
- Back-to-back loads, no ALU:
  - 6 consecutive mem pushes with distinct data.
  - Writes appear in push order, 1 per cycle, starting 2 cycles after the first push; mem_ready never drops.

Source files
------------

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - round-robin merge of ALU results and queued load results onto the register-file write port
module writeback_arbiter #(
    parameter int DEPTH = 2,
    parameter int DW    = 8,
    parameter int AW    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    input  logic [AW-1:0]              alu_addr,
    input  logic [DW-1:0]              alu_data,
    output logic                       alu_ready,
    input  logic                       mem_valid,
    input  logic [AW-1:0]              mem_addr,
    input  logic [DW-1:0]              mem_data,
    output logic                       mem_ready,
    output logic                       write_enable,
    output logic [AW-1:0]              write_addr,
    output logic [DW-1:0]              write_data,
    output logic [(1<<AW)-1:0]         pending,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int NREG = 1 << AW;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    grant_t         last_grant;
    logic [AW-1:0]  fifo_addr [DEPTH];
    logic [DW-1:0]  fifo_data [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    logic fifo_empty;
    logic push;
    logic pop;
    logic alu_grant;

    assign fifo_empty = (count == '0);
    assign mem_ready  = (count != CW'(DEPTH));
    // Arbitration looks only at registered state, so neither ready depends on its own valid.
    assign alu_ready  = fifo_empty || (last_grant == GRANT_MEM);
    assign alu_grant  = alu_valid && alu_ready;
    assign pop        = !fifo_empty && !alu_grant;
    assign push       = mem_valid && mem_ready;
    assign fifo_count = count;

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending = pending | (NREG'(1) << fifo_addr[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= mem_addr;
            fifo_data[wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            entry_valid  <= '0;
            last_grant   <= GRANT_MEM;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            // Push and pop never touch the same slot: a full FIFO refuses pushes.
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (wr_ptr == PW'(i))) begin
                    entry_valid[i] <= 1'b1;
                end else if (pop && (rd_ptr == PW'(i))) begin
                    entry_valid[i] <= 1'b0;
                end
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            if (alu_grant) begin
                last_grant   <= GRANT_ALU;
                write_enable <= 1'b1;
                write_addr   <= alu_addr;
                write_data   <= alu_data;
            end else if (pop) begin
                last_grant   <= GRANT_MEM;
                write_enable <= 1'b1;
                write_addr   <= fifo_addr[rd_ptr];
                write_data   <= fifo_data[rd_ptr];
            end else begin
                write_enable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed self-checking bench for writeback_arbiter
module tb_writeback_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alu_valid = 1'b0;
    logic [1:0] alu_addr = '0;
    logic [7:0] alu_data = '0;
    logic       alu_ready;
    logic       mem_valid = 1'b0;
    logic [1:0] mem_addr = '0;
    logic [7:0] mem_data = '0;
    logic       mem_ready;
    logic       write_enable;
    logic [1:0] write_addr;
    logic [7:0] write_data;
    logic [3:0] pending;
    logic [1:0] fifo_count;

    int tests_run = 0;
    int tests_failed = 0;

    writeback_arbiter #(.DEPTH(2), .DW(8), .AW(2)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .pending(pending), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        tests_run++; if (write_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %0b expected 0", write_enable); end
        tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL reset_pending: got %b expected 0000", pending); end
        tests_run++; if (fifo_count !== 2'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        tests_run++; if (mem_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_mem_ready: got %0b expected 1", mem_ready); end
        tests_run++; if (alu_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_alu_ready: got %0b expected 1", alu_ready); end
    endtask

    task automatic test_alu_only();
        do_reset();
        alu_valid = 1'b1; alu_addr = 2'd2; alu_data = 8'hA5;
        tests_run++; if (alu_ready !== 1'b1) begin tests_failed++; $display("FAIL alu_ready: got %0b expected 1", alu_ready); end
        step();
        alu_valid = 1'b0;
        tests_run++; if (write_enable !== 1'b1 || write_addr !== 2'd2 || write_data !== 8'hA5) begin tests_failed++; $display("FAIL alu_write: got we=%0b addr=%0d data=%h expected 1/2/a5", write_enable, write_addr, write_data); end
        step();
        tests_run++; if (write_enable !== 1'b0) begin tests_failed++; $display("FAIL alu_idle_we: got %0b expected 0", write_enable); end
    endtask

    task automatic test_fill();
        do_reset();
        mem_valid = 1'b1; mem_addr = 2'd1; mem_data = 8'h11;
        step();
        tests_run++; if (fifo_count !== 2'd1 || pending !== 4'b0010) begin tests_failed++; $display("FAIL fill_first: got count=%0d pending=%b expected 1/0010", fifo_count, pending); end
        mem_addr = 2'd3; mem_data = 8'h33;
        alu_valid = 1'b1; alu_addr = 2'd2; alu_data = 8'hAA;
        step();
        mem_valid = 1'b0;
        tests_run++; if (fifo_count !== 2'd2 || mem_ready !== 1'b0 || pending !== 4'b1010) begin tests_failed++; $display("FAIL fill_full: got count=%0d ready=%0b pending=%b expected 2/0/1010", fifo_count, mem_ready, pending); end
        tests_run++; if (write_enable !== 1'b1 || write_addr !== 2'd2 || write_data !== 8'hAA) begin tests_failed++; $display("FAIL fill_w0_alu: got we=%0b addr=%0d data=%h expected 1/2/aa", write_enable, write_addr, write_data); end
        tests_run++; if (alu_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_alu_blocked: got %0b expected 0", alu_ready); end
        step();
        tests_run++; if (write_enable !== 1'b1 || write_addr !== 2'd1 || write_data !== 8'h11) begin tests_failed++; $display("FAIL fill_w1_mem: got we=%0b addr=%0d data=%h expected 1/1/11", write_enable, write_addr, write_data); end
        tests_run++; if (pending !== 4'b1000 || fifo_count !== 2'd1) begin tests_failed++; $display("FAIL fill_pending1: got pending=%b count=%0d expected 1000/1", pending, fifo_count); end
        step();
        tests_run++; if (write_enable !== 1'b1 || write_addr !== 2'd2 || write_data !== 8'hAA) begin tests_failed++; $display("FAIL fill_w2_alu: got we=%0b addr=%0d data=%h expected 1/2/aa", write_enable, write_addr, write_data); end
        step();
        alu_valid = 1'b0;
        tests_run++; if (write_enable !== 1'b1 || write_addr !== 2'd3 || write_data !== 8'h33) begin tests_failed++; $display("FAIL fill_w3_mem: got we=%0b addr=%0d data=%h expected 1/3/33", write_enable, write_addr, write_data); end
        tests_run++; if (pending !== 4'b0000 || fifo_count !== 2'd0) begin tests_failed++; $display("FAIL fill_drained: got pending=%b count=%0d expected 0000/0", pending, fifo_count); end
        step();
        tests_run++; if (write_enable !== 1'b0) begin tests_failed++; $display("FAIL fill_idle: got %0b expected 0", write_enable); end
    endtask

    task automatic test_round_robin();
        do_reset();
        mem_valid = 1'b1; mem_addr = 2'd0; mem_data = 8'h44;
        step();
        mem_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 2'd1; alu_data = 8'h55;
        tests_run++; if (alu_ready !== 1'b1 || pending !== 4'b0001) begin tests_failed++; $display("FAIL rr_setup: got alu_ready=%0b pending=%b expected 1/0001", alu_ready, pending); end
        step();
        alu_valid = 1'b0;
        tests_run++; if (write_enable !== 1'b1 || write_addr !== 2'd1 || write_data !== 8'h55) begin tests_failed++; $display("FAIL rr_alu_first: got we=%0b addr=%0d data=%h expected 1/1/55", write_enable, write_addr, write_data); end
        step();
        tests_run++; if (write_enable !== 1'b1 || write_addr !== 2'd0 || write_data !== 8'h44) begin tests_failed++; $display("FAIL rr_mem_second: got we=%0b addr=%0d data=%h expected 1/0/44", write_enable, write_addr, write_data); end
        tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL rr_pending: got %b expected 0000", pending); end
    endtask

    task automatic test_full_pop();
        do_reset();
        mem_valid = 1'b1; mem_addr = 2'd1; mem_data = 8'h01;
        step();
        mem_addr = 2'd2; mem_data = 8'h02;
        alu_valid = 1'b1; alu_addr = 2'd3; alu_data = 8'h77;
        step();
        alu_valid = 1'b0;
        mem_addr = 2'd3; mem_data = 8'h03;
        tests_run++; if (fifo_count !== 2'd2 || mem_ready !== 1'b0) begin tests_failed++; $display("FAIL fp_full: got count=%0d ready=%0b expected 2/0", fifo_count, mem_ready); end
        step();
        alu_valid = 1'b1; alu_addr = 2'd0; alu_data = 8'h66;
        tests_run++; if (fifo_count !== 2'd1 || mem_ready !== 1'b1) begin tests_failed++; $display("FAIL fp_popped: got count=%0d ready=%0b expected 1/1", fifo_count, mem_ready); end
        tests_run++; if (write_enable !== 1'b1 || write_addr !== 2'd1 || write_data !== 8'h01) begin tests_failed++; $display("FAIL fp_w_mem1: got we=%0b addr=%0d data=%h expected 1/1/01", write_enable, write_addr, write_data); end
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        tests_run++; if (fifo_count !== 2'd2 || pending !== 4'b1100) begin tests_failed++; $display("FAIL fp_refill: got count=%0d pending=%b expected 2/1100", fifo_count, pending); end
        tests_run++; if (write_enable !== 1'b1 || write_addr !== 2'd0 || write_data !== 8'h66) begin tests_failed++; $display("FAIL fp_w_alu: got we=%0b addr=%0d data=%h expected 1/0/66", write_enable, write_addr, write_data); end
        step();
        tests_run++; if (write_enable !== 1'b1 || write_addr !== 2'd2 || write_data !== 8'h02) begin tests_failed++; $display("FAIL fp_w_mem2: got we=%0b addr=%0d data=%h expected 1/2/02", write_enable, write_addr, write_data); end
        step();
        tests_run++; if (write_enable !== 1'b1 || write_addr !== 2'd3 || write_data !== 8'h03) begin tests_failed++; $display("FAIL fp_w_mem3: got we=%0b addr=%0d data=%h expected 1/3/03", write_enable, write_addr, write_data); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c < 6) begin
                mem_valid = 1'b1; mem_addr = 2'(c % 4); mem_data = 8'(8'h10 + c);
                tests_run++; if (mem_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready c%0d: got %0b expected 1", c, mem_ready); end
            end else begin
                mem_valid = 1'b0;
            end
            if (c >= 2 && c < 8) begin
                tests_run++; if (write_enable !== 1'b1 || write_addr !== 2'((c - 2) % 4) || write_data !== 8'(8'h10 + c - 2)) begin tests_failed++; $display("FAIL b2b_write c%0d: got we=%0b addr=%0d data=%h expected 1/%0d/%h", c, write_enable, write_addr, write_data, (c - 2) % 4, 8'h10 + c - 2); end
            end else begin
                tests_run++; if (write_enable !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle c%0d: got %0b expected 0", c, write_enable); end
            end
            step();
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        mem_valid = 1'b1; mem_addr = 2'd1; mem_data = 8'hE1;
        step();
        mem_addr = 2'd2; mem_data = 8'hE2;
        alu_valid = 1'b1; alu_addr = 2'd0; alu_data = 8'hE0;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        tests_run++; if (fifo_count !== 2'd2) begin tests_failed++; $display("FAIL mr_queued: got %0d expected 2", fifo_count); end
        reset = 1'b1;
        step();
        tests_run++; if (write_enable !== 1'b0) begin tests_failed++; $display("FAIL mr_we_in_reset: got %0b expected 0", write_enable); end
        step();
        reset = 1'b0;
        tests_run++; if (fifo_count !== 2'd0 || pending !== 4'b0000) begin tests_failed++; $display("FAIL mr_dropped: got count=%0d pending=%b expected 0/0000", fifo_count, pending); end
        for (int c = 0; c < 3; c++) begin
            step();
            tests_run++; if (write_enable !== 1'b0) begin tests_failed++; $display("FAIL mr_no_write c%0d: got %0b expected 0", c, write_enable); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_fill();
        test_round_robin();
        test_full_pop();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
